hilo_unit: RTL
==============

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 31, range 4..31: maximum BUSY cycles allowed before the multiplier is declared hung.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 op_valid  in  1  EX-stage multiply-class instruction present.
REQ-005 op  in  3  opcode: 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU; 0 and 7 are no-op.
REQ-006 srca, srcb  in  32 each  rs and rt operands.
REQ-007 wr_hi, wr_lo, wdata  in  1, 1, 32  MTHI/MTLO write strobes and data.
REQ-008 flush  in  1  exception or branch cancel of the EX-stage instruction.
REQ-009 hi_out, lo_out  out  32 each  architectural HI/LO register values.
REQ-010 stall  out  1  pipeline hold request.
REQ-011 err  out  1  sticky multiplier-timeout flag.
REQ-012 m_in_valid, m_sign, m_mode[1:0], m_srca, m_srcb, m_in_hi, m_in_lo  out  multiplier request.
- m_sign=1 selects signed.
- m_mode: 00 = product, 01 = product+{in_hi,in_lo}, 10 = product-{in_hi,in_lo}.
REQ-013 m_out_valid, m_hi, m_lo  in  1, 32, 32  multiplier result.

Function
REQ-014 FSM states: IDLE and BUSY.
REQ-015 Accept condition: state IDLE && op_valid && op in 1..6 && !flush.
- On accept: latch srca, srcb, decoded sign/mode, and current HI/LO into operand registers.
- Next state: BUSY.
REQ-016 Decode table: MULT 1/00, MULTU 0/00, MADD 1/01, MADDU 0/01, MSUB 1/10, MSUBU 0/10.
REQ-017 m_srca, m_srcb, m_sign, m_mode, m_in_hi and m_in_lo are always driven from the latched registers.
- They do not change while in BUSY; the multiplier restarts its count on any input change.
REQ-018 m_in_valid is 1 exactly when state is BUSY; it is 0 in IDLE, so the multiplier count is cleared before each new operation.
REQ-019 In BUSY, m_out_valid=1 && !flush:
- HI<=m_hi and LO<=m_lo at that edge.
- Next state: IDLE.
- stall=0 in that same cycle.
REQ-020 stall is combinational and equals 1 in either case:
- the accept cycle;
- any BUSY cycle without completion, flush or timeout.
REQ-021 In BUSY, flush=1 returns to IDLE at the next edge.
- No HI/LO write, even if m_out_valid=1 in the same cycle; flush takes priority.
- stall=0 in that cycle.
REQ-022 wait_cnt behaviour:
- Cleared on accept; increments each BUSY cycle.
- When wait_cnt==WAIT_LIMIT-1 in a BUSY cycle without m_out_valid: err<=1 (sticky until rst), next state IDLE, HI/LO unchanged, stall=0 in that cycle.
REQ-023 wr_hi/wr_lo update HI/LO from wdata at the edge, only when state is IDLE and no accept occurs that cycle.
- Ignored in BUSY and in the accept cycle; accept takes priority.
- wr_hi and wr_lo together write both registers.
REQ-024 hi_out/lo_out always reflect the registers; there is no write bypass.
REQ-025 op 0 or 7 with op_valid=1 in IDLE has no effect; stall stays 0.
REQ-026 Completion to IDLE and a new accept cannot occur in the same cycle; a back-to-back operation is accepted on the following cycle.

Reset
REQ-027 rst=1 asynchronously forces all of the following, including mid-BUSY:
- state IDLE; HI=LO=0; err=0; wait_cnt=0; all latched operand registers 0.
- Outputs then read stall=0, m_in_valid=0, m_sign=0, m_mode=00.
REQ-028 After rst deasserts, the first rising edge may accept an operation.

Verification
REQ-029 MULT with srca=0xFFFFFFFE, srcb=3 -> stall=1 until the m_out_valid cycle; then hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA; m_in_valid=0 next cycle.
REQ-030 HI=0, LO=0xFFFFFFFF, MADDU with srca=1, srcb=1 -> m_in_hi=0, m_in_lo=0xFFFFFFFF, m_mode=01 held stable; result HI=1, LO=0.
REQ-031 MULT accepted, flush=1 on 2nd BUSY cycle with m_out_valid=1 -> HI/LO unchanged, stall=0 that cycle, IDLE next cycle.
REQ-032 WAIT_LIMIT=8, model never asserts m_out_valid -> stall=1 for accept + 7 BUSY cycles, 0 on the 8th BUSY cycle; err=1 from then until rst; HI/LO unchanged.
REQ-033 Two checks on wr_hi/wr_lo:
- In IDLE, wr_hi=wr_lo=1 with wdata=0x00001234 -> both registers read 0x00001234.
- During BUSY, wr_hi=1 with wdata=0xDEAD -> ignored.
REQ-034 rst pulsed asynchronously (between edges) mid-BUSY -> hi_out=lo_out=0, stall=0, m_in_valid=0, err=0 immediately; a new MULT is accepted after release.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register file with a handshake to an external multi-cycle multiplier.
// Handles MULT/MADD/MSUB (signed and unsigned), MTHI/MTLO, flush, and a watchdog on the multiplier.
module hilo_unit #(
  parameter int unsigned WAIT_LIMIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        stall,
  output logic        err,
  output logic        m_in_valid,
  output logic        m_sign,
  output logic [1:0]  m_mode,
  output logic [31:0] m_srca,
  output logic [31:0] m_srcb,
  output logic [31:0] m_in_hi,
  output logic [31:0] m_in_lo,
  input  logic        m_out_valid,
  input  logic [31:0] m_hi,
  input  logic [31:0] m_lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] CNT_LAST = 5'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        err_q, err_d;
  logic [4:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] srca_q, srca_d, srcb_q, srcb_d;
  logic [31:0] in_hi_q, in_hi_d, in_lo_q, in_lo_d;
  logic        sign_q, sign_d;
  logic [1:0]  mode_q, mode_d;

  logic        accept;
  logic        sign_dec;
  logic [1:0]  mode_dec;

  // Odd opcodes are the signed variants; pairs (1,2),(3,4),(5,6) share a mode.
  assign sign_dec = op[0];
  assign mode_dec = 2'((op - 3'd1) >> 1);
  assign accept   = (state_q == IDLE) && op_valid && (op != 3'd0) && (op != 3'd7) && !flush;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    in_hi_d    = in_hi_q;
    in_lo_d    = in_lo_q;
    sign_d     = sign_q;
    mode_d     = mode_q;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          srca_d     = srca;
          srcb_d     = srcb;
          sign_d     = sign_dec;
          mode_d     = mode_dec;
          in_hi_d    = hi_q;
          in_lo_d    = lo_q;
          wait_cnt_d = 5'd0;
          state_d    = BUSY;
          stall      = 1'b1;
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      BUSY: begin
        wait_cnt_d = wait_cnt_q + 5'd1;
        // Flush wins over both completion and timeout.
        if (flush) begin
          state_d = IDLE;
        end else if (m_out_valid) begin
          hi_d    = m_hi;
          lo_d    = m_lo;
          state_d = IDLE;
        end else if (wait_cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      in_hi_q    <= '0;
      in_lo_q    <= '0;
      sign_q     <= 1'b0;
      mode_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      in_hi_q    <= in_hi_d;
      in_lo_q    <= in_lo_d;
      sign_q     <= sign_d;
      mode_q     <= mode_d;
    end
  end

  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign err        = err_q;
  assign m_in_valid = (state_q == BUSY);
  assign m_sign     = sign_q;
  assign m_mode     = mode_q;
  assign m_srca     = srca_q;
  assign m_srcb     = srcb_q;
  assign m_in_hi    = in_hi_q;
  assign m_in_lo    = in_lo_q;

endmodule
